settle_mon: RTL and testbench
=============================

SETTLE_MON -- requirements
Module: settle_mon

Interface
REQ-001 Parameter NCH, default 2, number of monitored signed channels (1..8).
REQ-002 Parameter W, default 16, sample width per channel, two's complement.
REQ-003 Parameter CNT_W, default 24, width of timeout, settle and elapsed counters.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; arms (or re-arms) the monitor.
REQ-007 samp  in  NCH*W  packed signed samples; channel i at bits [i*W +: W].
REQ-008 samp_vld  in  1  qualifies samp for all channels this cycle.
REQ-009 lo, hi  in  W each  signed inclusive window bounds; sampled at start.
REQ-010 timeout  in  CNT_W  cycle budget from start; 0 = no timeout; sampled at start.
REQ-011 settle  in  CNT_W  consecutive in-window valid samples needed to lock; 0 treated as 1; sampled at start.
REQ-012 busy  out  1  monitor armed and unresolved.
REQ-013 done  out  1  one-cycle pulse when run resolves.
REQ-014 pass  out  1  all channels locked; held until next start or reset.
REQ-015 ch_lock, ch_fail  out  NCH each  per-channel final status; held until next start or reset.
REQ-016 elapsed  out  CNT_W  cycles since start; saturates at all-ones; frozen at resolution.

Function
REQ-017 Per-channel FSM states: IDLE, WAIT_IN, SETTLING, LOCKED, FAILED.
REQ-018 start: all channels go to WAIT_IN, settle counters and elapsed cleared, busy=1 next cycle; lo/hi/timeout/settle captured.
REQ-019 First sample evaluated is the first samp_vld cycle after start; samp_vld in the start cycle is ignored.
REQ-020 In-window test: lo <= sample <= hi, signed compare at full W; lo > hi means no sample is ever in window.
REQ-021 WAIT_IN: valid in-window sample -> SETTLING, count=1; if count reaches settle -> LOCKED directly.
REQ-022 SETTLING: valid in-window sample increments count; count == settle -> LOCKED; valid out-of-window sample -> WAIT_IN, count=0; invalid cycles hold.
REQ-023 elapsed increments every busy cycle; when timeout != 0 and elapsed+1 == timeout, every channel not LOCKED -> FAILED.
REQ-024 Lock and timeout in same cycle: LOCKED wins.
REQ-025 Run resolves when every channel is LOCKED or FAILED; done pulses one cycle after, busy drops with done, pass = all LOCKED.
REQ-026 start while busy aborts the current run without done and restarts per REQ-018; start in the done cycle starts a new run.
REQ-027 No samp_vld ever and timeout=0: busy stays high indefinitely (legal).

Reset
REQ-028 rst forces: all channels IDLE, busy=0, done=0, pass=0, ch_lock=0, ch_fail=0, elapsed=0, captured config=0.
REQ-029 rst mid-run abandons the run with no done pulse; first start after deassertion behaves as REQ-018.

Configuration
REQ-030 Macro SETTLE_MON_DROPOUT_EN defined: a LOCKED channel receiving a valid out-of-window sample while busy -> FAILED immediately.
REQ-031 Macro undefined: LOCKED is sticky until next start or reset; dropouts ignored.

Structure
REQ-032 Package settle_mon_pkg holds ch_state_e enum (5 states) and default values of NCH, W, CNT_W.
REQ-033 Sub-module settle_ch implements one channel FSM plus settle counter; settle_mon instantiates NCH copies with a generate loop and owns elapsed, timeout compare and done/pass logic.

Verification
REQ-034 NCH=2, lo=-255, hi=511, settle=4, timeout=100; both channels in window from cycle 1 -> done at cycle 5, pass=1, elapsed=5.
REQ-035 Ch0 in window, ch1 fixed at 600, timeout=50 -> done after cycle 50, pass=0, ch_lock=01, ch_fail=10.
REQ-036 Ch0 toggles in/out every 3 valid samples, settle=4, timeout=0 -> never locks, busy stays 1; new start with steady input -> passes.
REQ-037 4th in-window sample coincides with timeout cycle -> channel LOCKED, pass=1.
REQ-038 lo=10, hi=5 -> all channels FAILED at timeout, pass=0.
REQ-039 With SETTLE_MON_DROPOUT_EN: ch0 locks, ch1 still settling, ch0 gets sample 700 -> ch0 FAILED, final pass=0; without macro, same stimulus -> pass=1.

Source files
------------

// File: rtl/settle_mon_pkg.sv
// Shared types and default sizing for the settle monitor.
// The channel state encoding is exported so that checkers can decode the debug bus.
package settle_mon_pkg;

  localparam int NCH_DEF   = 2;
  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_SETTLING,
    ST_LOCKED,
    ST_FAILED
  } ch_state_e;

endpackage

// File: rtl/settle_ch.sv
// One monitored channel: window test, consecutive-sample settle counter and state FSM.
// Define SETTLE_MON_DROPOUT_EN to make an out-of-window sample fail an already LOCKED channel.
module settle_ch
  import settle_mon_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_en,
  input  logic                i_vld,
  input  logic signed [W-1:0] i_samp,
  input  logic signed [W-1:0] i_lo,
  input  logic signed [W-1:0] i_hi,
  input  logic [CNT_W-1:0]    i_settle,
  input  logic                i_tmo,
  output ch_state_e           o_state
);

  ch_state_e        r_state;
  ch_state_e        w_nstate;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_ncnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_in;

  // An inverted window (lo > hi) can never satisfy both bounds, so needs no special case.
  assign w_in      = (i_samp >= i_lo) && (i_samp <= i_hi);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    if (i_start) begin
      w_nstate = ST_WAIT_IN;
      w_ncnt   = '0;
    end else if (i_en) begin
      case (r_state)
        ST_WAIT_IN: begin
          if (i_vld && w_in) begin
            w_ncnt   = CNT_W'(1);
            w_nstate = (i_settle == CNT_W'(1)) ? ST_LOCKED : ST_SETTLING;
          end
        end
        ST_SETTLING: begin
          if (i_vld) begin
            if (w_in) begin
              w_ncnt   = w_cnt_inc;
              w_nstate = (w_cnt_inc == i_settle) ? ST_LOCKED : ST_SETTLING;
            end else begin
              w_ncnt   = '0;
              w_nstate = ST_WAIT_IN;
            end
          end
        end
`ifdef SETTLE_MON_DROPOUT_EN
        ST_LOCKED: begin
          if (i_vld && !w_in) w_nstate = ST_FAILED;
        end
`else
        ST_LOCKED: begin
        end
`endif
        default: begin
        end
      endcase
      // Timeout is applied after the lock decision so a same-cycle lock survives.
      if (i_tmo && (w_nstate != ST_LOCKED)) w_nstate = ST_FAILED;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/settle_mon.sv
// Multi-channel settle monitor: arms on i_start, resolves when every channel locks or fails.
// Optional macro SETTLE_MON_DROPOUT_EN (handled in settle_ch) makes locked channels fail on dropout.
module settle_mon
  import settle_mon_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [NCH*W-1:0]    i_samp,
  input  logic                i_samp_vld,
  input  logic signed [W-1:0] i_lo,
  input  logic signed [W-1:0] i_hi,
  input  logic [CNT_W-1:0]    i_timeout,
  input  logic [CNT_W-1:0]    i_settle,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [NCH-1:0]      o_ch_lock,
  output logic [NCH-1:0]      o_ch_fail,
  output logic [CNT_W-1:0]    o_elapsed,
  output logic [NCH*3-1:0]    o_dbg_state
);

  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [NCH-1:0]      r_lock;
  logic [NCH-1:0]      r_fail;
  logic [CNT_W-1:0]    r_elapsed;
  logic signed [W-1:0] r_lo;
  logic signed [W-1:0] r_hi;
  logic [CNT_W-1:0]    r_timeout;
  logic [CNT_W-1:0]    r_settle;

  ch_state_e           w_st [NCH];
  logic [NCH-1:0]      w_lock;
  logic [NCH-1:0]      w_fail;
  logic                w_resolved;
  logic                w_en;
  logic                w_tmo;
  logic [CNT_W:0]      w_elapsed_inc;

  assign w_resolved    = &(w_lock | w_fail);
  // Channels freeze once resolved so reported status matches the latched result.
  assign w_en          = r_busy && !w_resolved;
  // One bit wider so a saturated counter can never alias onto the timeout value.
  assign w_elapsed_inc = {1'b0, r_elapsed} + (CNT_W + 1)'(1);
  assign w_tmo         = w_en && (r_timeout != '0) && (w_elapsed_inc == {1'b0, r_timeout});

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    settle_ch #(
      .W    (W),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_start (i_start),
      .i_en    (w_en),
      .i_vld   (i_samp_vld),
      .i_samp  (i_samp[g*W +: W]),
      .i_lo    (r_lo),
      .i_hi    (r_hi),
      .i_settle(r_settle),
      .i_tmo   (w_tmo),
      .o_state (w_st[g])
    );
    assign w_lock[g]             = (w_st[g] == ST_LOCKED);
    assign w_fail[g]             = (w_st[g] == ST_FAILED);
    assign o_dbg_state[g*3 +: 3] = w_st[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_lock    <= '0;
      r_fail    <= '0;
      r_elapsed <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_timeout <= '0;
      r_settle  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy    <= 1'b1;
        r_pass    <= 1'b0;
        r_lock    <= '0;
        r_fail    <= '0;
        r_elapsed <= '0;
        r_lo      <= i_lo;
        r_hi      <= i_hi;
        r_timeout <= i_timeout;
        r_settle  <= (i_settle == '0) ? CNT_W'(1) : i_settle;
      end else if (r_busy) begin
        if (r_elapsed != '1) r_elapsed <= r_elapsed + CNT_W'(1);
        if (w_resolved) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= &w_lock;
          r_lock <= w_lock;
          r_fail <= w_fail;
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_ch_lock = r_lock;
  assign o_ch_fail = r_fail;
  assign o_elapsed = r_elapsed;

endmodule

// File: tb/tb_settle_mon.sv
// Directed bench for settle_mon: drivers push expected run results, a done-monitor pops and compares.
// Expected records are {pass, ch_lock[1:0], ch_fail[1:0], elapsed[23:0]}.
module tb_settle_mon;

  localparam int NCH   = 2;
  localparam int W     = 16;
  localparam int CNT_W = 24;
  localparam int RW    = 1 + 2 * NCH + CNT_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_start = 1'b0;
  logic [NCH*W-1:0]    i_samp = '0;
  logic                i_samp_vld = 1'b0;
  logic signed [W-1:0] i_lo = '0;
  logic signed [W-1:0] i_hi = '0;
  logic [CNT_W-1:0]    i_timeout = '0;
  logic [CNT_W-1:0]    i_settle = '0;
  logic                o_busy;
  logic                o_done;
  logic                o_pass;
  logic [NCH-1:0]      o_ch_lock;
  logic [NCH-1:0]      o_ch_fail;
  logic [CNT_W-1:0]    o_elapsed;
  logic [NCH*3-1:0]    o_dbg_state;

  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  settle_mon #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_samp     (i_samp),
    .i_samp_vld (i_samp_vld),
    .i_lo       (i_lo),
    .i_hi       (i_hi),
    .i_timeout  (i_timeout),
    .i_settle   (i_settle),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_pass     (o_pass),
    .o_ch_lock  (o_ch_lock),
    .o_ch_fail  (o_ch_fail),
    .o_elapsed  (o_elapsed),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor / scoreboard: every done pulse must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && o_done) begin
      logic [RW-1:0] act;
      logic [RW-1:0] exp;
      act = {o_pass, o_ch_lock, o_ch_fail, o_elapsed};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got pass=%0b lock=%b fail=%b elapsed=%0d, no run result expected",
                 o_pass, o_ch_lock, o_ch_fail, o_elapsed);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL done_result got pass=%0b lock=%b fail=%b elapsed=%0d expected pass=%0b lock=%b fail=%b elapsed=%0d",
                   o_pass, o_ch_lock, o_ch_fail, o_elapsed,
                   exp[RW-1], exp[RW-2 -: NCH], exp[CNT_W +: NCH], exp[CNT_W-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic pass, input logic [1:0] lock, input logic [1:0] fail, input int el);
    exp_q.push_back({pass, lock, fail, CNT_W'(el)});
  endtask

  task automatic start_run(input int lo, input int hi, input int tmo, input int st,
                           input logic vld, input int s0, input int s1);
    @(posedge clk);
    #1;
    i_start    = 1'b1;
    i_lo       = W'(lo);
    i_hi       = W'(hi);
    i_timeout  = CNT_W'(tmo);
    i_settle   = CNT_W'(st);
    i_samp_vld = vld;
    i_samp     = {W'(s1), W'(s0)};
  endtask

  task automatic step(input logic vld, input int s0, input int s1);
    @(posedge clk);
    #1;
    i_start    = 1'b0;
    i_samp_vld = vld;
    i_samp     = {W'(s1), W'(s0)};
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < budget);
    if (o_busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle busy still 1 after %0d cycles, expected 0", budget);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_pass", 64'(o_pass), 64'd0);
    check("rst_lock", 64'(o_ch_lock), 64'd0);
    check("rst_fail", 64'(o_ch_fail), 64'd0);
    check("rst_elapsed", 64'(o_elapsed), 64'd0);

    // both in window from cycle 1, inclusive bounds; vld in start cycle ignored
    push(1'b1, 2'b11, 2'b00, 5);
    start_run(-255, 511, 100, 4, 1'b1, -255, 511);
    step(1'b1, -255, 511);
    step(1'b1, 511, -255);
    step(1'b1, 0, 0);
    step(1'b1, 511, 511);
    step(1'b0, 0, 0);

    // next start lands in the done cycle; ch1 stuck at 600 -> timeout at 50
    push(1'b0, 2'b01, 2'b10, 51);
    start_run(-255, 511, 50, 4, 1'b0, 0, 0);
    step(1'b1, 0, 600);
    wait_idle(100);

    // gaps hold the count; ch1 starts just out of window
    push(1'b1, 2'b11, 2'b00, 10);
    start_run(-255, 511, 0, 4, 1'b0, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      if (c % 2 == 1) step(1'b1, 100, (c == 1) ? 512 : -255);
      else            step(1'b0, 1000, 1000);
    end
    step(1'b0, 0, 0);
    wait_idle(50);

    // 4th in-window sample on the timeout cycle: lock wins
    push(1'b1, 2'b11, 2'b00, 5);
    start_run(-255, 511, 4, 4, 1'b0, 0, 0);
    repeat (4) step(1'b1, 3, -3);
    step(1'b0, 0, 0);
    wait_idle(50);

    // inverted window never accepts
    push(1'b0, 2'b00, 2'b11, 21);
    start_run(10, 5, 20, 4, 1'b0, 0, 0);
    step(1'b1, 7, 7);
    wait_idle(50);

    // settle=0 behaves as 1
    push(1'b1, 2'b11, 2'b00, 2);
    start_run(-255, 511, 0, 0, 1'b0, 0, 0);
    step(1'b1, 1, 1);
    step(1'b0, 0, 0);
    wait_idle(50);

    // dropout after ch0 lock while ch1 still settling
`ifdef SETTLE_MON_DROPOUT_EN
    push(1'b0, 2'b10, 2'b01, 6);
`else
    push(1'b1, 2'b11, 2'b00, 6);
`endif
    start_run(-255, 511, 0, 4, 1'b0, 0, 0);
    step(1'b1, 100, 600);
    step(1'b1, 100, 0);
    step(1'b1, 100, 0);
    step(1'b1, 100, 0);
    step(1'b1, 700, 0);
    step(1'b0, 0, 0);
    wait_idle(50);

    // ch0 toggles every 3 samples: never locks with no timeout
    start_run(-255, 511, 0, 4, 1'b0, 0, 0);
    for (int i = 0; i < 30; i++) step(1'b1, ((i / 3) % 2 == 0) ? 100 : 600, 100);
    @(negedge clk);
    check("toggle_busy", 64'(o_busy), 64'd1);
    check("toggle_elapsed", 64'(o_elapsed), 64'd29);
    // restart while busy: aborted run must not pulse done
    push(1'b1, 2'b11, 2'b00, 5);
    start_run(-255, 511, 0, 4, 1'b1, 100, 100);
    repeat (4) step(1'b1, 100, 100);
    step(1'b0, 0, 0);
    wait_idle(50);

    // async reset mid-run abandons it silently
    start_run(-255, 511, 0, 4, 1'b0, 0, 0);
    step(1'b1, 1, 1);
    step(1'b1, 1, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_elapsed", 64'(o_elapsed), 64'd0);
    check("midrst_dbg_state", 64'(o_dbg_state), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(1'b1, 2'b11, 2'b00, 5);
    start_run(-255, 511, 0, 4, 1'b0, 0, 0);
    repeat (4) step(1'b1, -1, 2);
    step(1'b0, 0, 0);
    wait_idle(50);

    repeat (5) @(negedge clk);
    check("results_outstanding", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
